decompression_engine: RTL and testbench

// Clocked, parametrised successor to the combinational instruction decompressor. Streams the

---
 rtl/decompression_engine.sv | 167 ++++++++++++++++
 tb/tb_decompression_engine.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decompression_engine.sv
// decompression_engine: streams compressed code from a synchronous ROM, expands
// dictionary tokens into repeated instructions, and emits them over valid/ready.
// Optional feature macro: DECOMP_STATS_EN (adds tok_count / word_count outputs).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, code_words          restart stream; number of compressed words
//   mem_rd, mem_addr, mem_rdata  code ROM read port (data valid cycle after mem_rd)
//   dict_we, dict_waddr, dict_wdata  runtime dictionary load ({count, instruction})
//   out_valid, out_ready, out_instr, out_pc  expanded instruction stream
//   busy, done                 status
//   tok_count, word_count      (DECOMP_STATS_EN only) decode / emit counters
module decompression_engine #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DICT_DEPTH = 16,
  parameter int unsigned CNT_W      = 4,
  localparam int unsigned IDX_W     = $clog2(DICT_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       code_words,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    dict_we,
  input  logic [IDX_W-1:0]        dict_waddr,
  input  logic [CNT_W+DATA_W-1:0] dict_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_instr,
  output logic [DATA_W-1:0]       out_pc,
  output logic                    busy,
  output logic                    done
`ifdef DECOMP_STATS_EN
  ,
  output logic [31:0]             tok_count,
  output logic [31:0]             word_count
`endif
);

  localparam int unsigned ENTRY_W = CNT_W + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   caddr;
  logic [ADDR_W-1:0]   cw;
  logic [CNT_W-1:0]    rep;
  logic [ENTRY_W-1:0]  dict [DICT_DEPTH];

  logic                is_tok;
  logic [IDX_W-1:0]    idx;
  logic [ENTRY_W-1:0]  entry;
  logic [DATA_W-1:0]   dec_instr;
  logic [CNT_W-1:0]    dec_rep;
  logic                fire;

  // Dictionary storage; intentionally not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (dict_we) dict[dict_waddr] <= dict_wdata;
  end

  // Decode the ROM word arriving this cycle; a zero repeat count means one emit.
  always_comb begin
    is_tok    = (mem_rdata < DATA_W'(DICT_DEPTH));
    idx       = mem_rdata[IDX_W-1:0];
    entry     = dict[idx];
    dec_instr = mem_rdata;
    dec_rep   = CNT_W'(1);
    if (is_tok) begin
      dec_instr = entry[DATA_W-1:0];
      dec_rep   = (entry[DATA_W+:CNT_W] == '0) ? CNT_W'(1) : entry[DATA_W+:CNT_W];
    end
  end

  assign fire = out_valid && out_ready;

  // Main FSM; mem_rd/mem_addr are set on entry to FETCH so the ROM sees the
  // strobe during the FETCH cycle and its data lands during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      caddr      <= '0;
      cw         <= '0;
      rep        <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef DECOMP_STATS_EN
      tok_count  <= '0;
      word_count <= '0;
`endif
    end else if (start) begin
      // Restart or abort: any in-flight ROM data is ignored because FETCH never latches.
      state      <= S_FETCH;
      caddr      <= '0;
      cw         <= code_words;
      rep        <= '0;
      mem_rd     <= (code_words != '0);
      mem_addr   <= '0;
      out_valid  <= 1'b0;
      out_pc     <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
`ifdef DECOMP_STATS_EN
      tok_count  <= '0;
      word_count <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_FETCH: begin
          mem_rd <= 1'b0;
          if (caddr == cw) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          out_instr <= dec_instr;
          rep       <= dec_rep;
          caddr     <= caddr + ADDR_W'(1);
          out_valid <= 1'b1;
          state     <= S_EMIT;
`ifdef DECOMP_STATS_EN
          if (is_tok && (tok_count != 32'hFFFF_FFFF)) tok_count <= tok_count + 32'd1;
`endif
        end
        S_EMIT: begin
          if (fire) begin
            out_pc <= out_pc + DATA_W'(1);
            rep    <= rep - CNT_W'(1);
`ifdef DECOMP_STATS_EN
            if (word_count != 32'hFFFF_FFFF) word_count <= word_count + 32'd1;
`endif
            if (rep == CNT_W'(1)) begin
              out_valid <= 1'b0;
              state     <= S_FETCH;
              mem_rd    <= (caddr != cw);
              mem_addr  <= caddr;
            end
          end
        end
        S_DONE: begin
          out_valid <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decompression_engine.sv
// Self-checking bench for decompression_engine: ROM model, scoreboard of
// expected {instr, pc} pairs popped on each output handshake, directed steps.
module tb_decompression_engine;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic [ADDR_W-1:0]       code_words;
  logic                    mem_rd;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    dict_we;
  logic [IDX_W-1:0]        dict_waddr;
  logic [CNT_W+DATA_W-1:0] dict_wdata;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_instr;
  logic [DATA_W-1:0]       out_pc;
  logic                    busy;
  logic                    done;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rom [512];
  int          checks = 0;
  int          errors = 0;
  int          n_emit = 0;
  bit          rd_seen = 0;
  bit          vld_seen = 0;

  decompression_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .code_words (code_words),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .dict_we    (dict_we),
    .dict_waddr (dict_waddr),
    .dict_wdata (dict_wdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous code ROM.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= rom[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: a handshake seen at negedge completes on the following posedge.
  always @(negedge clk) begin
    if (mem_rd) rd_seen = 1;
    if (out_valid) vld_seen = 1;
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      n_emit++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed instr %h pc %0d expected no output", out_instr, out_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_instr", 64'(out_instr), 64'(e.instr));
        chk("sb_pc", 64'(out_pc), 64'(e.pc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] n);
    code_words = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic dict_write(input logic [IDX_W-1:0] i, input logic [CNT_W-1:0] c,
                            input logic [31:0] instr);
    dict_we    = 1'b1;
    dict_waddr = i;
    dict_wdata = {c, instr};
    tick();
    dict_we    = 1'b0;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) break;
      tick();
    end
    chk("done_within_budget", 64'(done), 64'd1);
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_valid) break;
      tick();
    end
    chk("valid_within_budget", 64'(out_valid), 64'd1);
  endtask

  initial begin
    int base;
    rst_n      = 1'b0;
    start      = 1'b0;
    code_words = '0;
    dict_we    = 1'b0;
    dict_waddr = '0;
    dict_wdata = '0;
    out_ready  = 1'b0;
    for (int i = 0; i < 512; i++) rom[i] = 32'h0000_1000 + 32'(i);
    tick();
    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    chk("rst_out_instr", 64'(out_instr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Literals only, with latency checks
    rom[0] = 32'h0040_0093;
    rom[1] = 32'h0050_0113;
    out_ready = 1'b1;
    push(32'h0040_0093, 0);
    push(32'h0050_0113, 1);
    pulse_start(9'd2);
    chk("lit_c1_mem_rd", 64'(mem_rd), 64'd1);
    chk("lit_c1_mem_addr", 64'(mem_addr), 64'd0);
    chk("lit_c1_busy", 64'(busy), 64'd1);
    tick();
    chk("lit_c2_mem_rd", 64'(mem_rd), 64'd0);
    chk("lit_c2_valid", 64'(out_valid), 64'd0);
    tick();
    chk("lit_c3_valid", 64'(out_valid), 64'd1);
    chk("lit_c3_instr", 64'(out_instr), 64'h0040_0093);
    chk("lit_c3_pc", 64'(out_pc), 64'd0);
    wait_done(50);
    chk("lit_q_empty", 64'(exp_q.size()), 64'd0);
    chk("lit_final_pc", 64'(out_pc), 64'd2);
    chk("lit_busy_after", 64'(busy), 64'd0);
    chk("lit_valid_after", 64'(out_valid), 64'd0);

    // Token with repeat 2
    dict_write(4'hA, 4'd2, 32'h0020_81B3);
    rom[0] = 32'h0000_000A;
    push(32'h0020_81B3, 0);
    push(32'h0020_81B3, 1);
    pulse_start(9'd1);
    wait_done(50);
    chk("tok_q_empty", 64'(exp_q.size()), 64'd0);

    // Repeat count 0 behaves as 1
    dict_write(4'h3, 4'd0, 32'h1234_5678);
    rom[0] = 32'h0000_0003;
    base = n_emit;
    push(32'h1234_5678, 0);
    pulse_start(9'd1);
    wait_done(50);
    chk("cnt0_emits", 64'(n_emit - base), 64'd1);
    chk("cnt0_q_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: 5 cycles of out_ready low while a token is emitting
    dict_write(4'h5, 4'd3, 32'hCAFE_F00D);
    rom[0] = 32'h0000_0005;
    rom[1] = 32'h0010_0073;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hCAFE_F00D, 32'(i));
    push(32'h0010_0073, 3);
    pulse_start(9'd2);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_instr", 64'(out_instr), 64'hCAFE_F00D);
      chk("bp_pc", 64'(out_pc), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    wait_done(100);
    chk("bp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("bp_final_pc", 64'(out_pc), 64'd4);

    // Restart mid-token repeat
    dict_write(4'h7, 4'd5, 32'hDEAD_BEEF);
    rom[0] = 32'h0000_0007;
    rom[1] = 32'h00A0_0093;
    for (int i = 0; i < 5; i++) push(32'hDEAD_BEEF, 32'(i));
    push(32'h00A0_0093, 5);
    base = n_emit;
    pulse_start(9'd2);
    for (int i = 0; i < 50; i++) begin
      if (n_emit - base >= 2) break;
      tick();
    end
    chk("rs_partial_emits", 64'(n_emit - base >= 2), 64'd1);
    out_ready = 1'b0;
    tick();
    exp_q.delete();
    for (int i = 0; i < 5; i++) push(32'hDEAD_BEEF, 32'(i));
    push(32'h00A0_0093, 5);
    pulse_start(9'd2);
    chk("rs_valid_dropped", 64'(out_valid), 64'd0);
    chk("rs_pc_cleared", 64'(out_pc), 64'd0);
    chk("rs_busy", 64'(busy), 64'd1);
    chk("rs_done", 64'(done), 64'd0);
    chk("rs_mem_rd", 64'(mem_rd), 64'd1);
    chk("rs_mem_addr", 64'(mem_addr), 64'd0);
    out_ready = 1'b1;
    wait_done(200);
    chk("rs_q_empty", 64'(exp_q.size()), 64'd0);
    chk("rs_final_pc", 64'(out_pc), 64'd6);

    // Empty stream
    tick();
    rd_seen  = 0;
    vld_seen = 0;
    pulse_start(9'd0);
    chk("empty_c1_done", 64'(done), 64'd0);
    chk("empty_c1_busy", 64'(busy), 64'd1);
    tick();
    chk("empty_c2_done", 64'(done), 64'd1);
    chk("empty_c2_busy", 64'(busy), 64'd0);
    tick();
    chk("empty_no_mem_rd", 64'(rd_seen), 64'd0);
    chk("empty_no_valid", 64'(vld_seen), 64'd0);

    // Reset mid-stream, then confirm dictionary survived reset
    rom[0] = 32'h0000_000A;
    out_ready = 1'b0;
    pulse_start(9'd1);
    wait_valid(20);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_pc", 64'(out_pc), 64'd0);
    chk("mrst_instr", 64'(out_instr), 64'd0);
    chk("mrst_mem_rd", 64'(mem_rd), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    push(32'h0020_81B3, 0);
    push(32'h0020_81B3, 1);
    pulse_start(9'd1);
    wait_done(50);
    chk("dict_kept_q_empty", 64'(exp_q.size()), 64'd0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
